// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: local word RAM below MMIO_BASE, and an MMIO page above it
// with TX/RX byte FIFOs, a status word and a free-running cycle counter.
module dmem_mmio_responder #(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] di,
    output logic [31:0] dout,
    output logic        stall,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int PW = FW + 1;

    localparam logic [31:0] OFF_TX     = 32'h0;
    localparam logic [31:0] OFF_RX     = 32'h4;
    localparam logic [31:0] OFF_STATUS = 32'h8;
    localparam logic [31:0] OFF_CYCLE  = 32'hC;

    logic [31:0] mem [RAM_WORDS];
    logic [7:0]  tx_mem [FIFO_DEPTH];
    logic [7:0]  rx_mem [FIFO_DEPTH];

    logic [PW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
    logic [PW-1:0] tx_cnt, rx_cnt;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [31:0]   cycle_cnt;

    logic          is_mmio;
    logic [31:0]   offset;
    logic [AW-1:0] ram_idx;
    logic          accepted;
    logic          ram_we, ram_re;
    logic          tx_push, tx_pop, rx_push, rx_pop, cyc_load;
    logic [31:0]   mmio_rdata;
    logic          unused_addr_bits;

    assign is_mmio  = (addr >= MMIO_BASE);
    assign offset   = addr - MMIO_BASE;
    assign ram_idx  = addr[AW+1:2];
    // Low byte-offset and upper address bits are dropped so the RAM aliases.
    assign unused_addr_bits = ^{addr[1:0], addr[31:AW+2]};

    assign tx_cnt   = tx_wptr - tx_rptr;
    assign rx_cnt   = rx_wptr - rx_rptr;
    assign tx_full  = (tx_cnt == PW'(FIFO_DEPTH));
    assign rx_full  = (rx_cnt == PW'(FIFO_DEPTH));
    assign tx_empty = (tx_cnt == '0);
    assign rx_empty = (rx_cnt == '0);

    // Only a TX push into a full FIFO is refused; a same-cycle TX pop does not help.
    assign stall    = en & we & is_mmio & (offset == OFF_TX) & tx_full & ~rst;
    assign accepted = en & ~stall;

    assign ram_we   = accepted & we & ~is_mmio;
    assign ram_re   = accepted & ~we;
    assign tx_push  = accepted & we & is_mmio & (offset == OFF_TX);
    assign cyc_load = accepted & we & is_mmio & (offset == OFF_CYCLE);
    assign rx_pop   = accepted & ~we & is_mmio & (offset == OFF_RX) & ~rx_empty;

    assign tx_valid = ~tx_empty & ~rst;
    assign tx_data  = tx_mem[tx_rptr[FW-1:0]];
    assign tx_pop   = tx_valid & tx_ready;

    assign rx_ready = ~rx_full & ~rst;
    assign rx_push  = rx_valid & rx_ready;

    always_comb begin
        mmio_rdata = 32'h0;
        case (offset)
            OFF_RX:     mmio_rdata = rx_empty ? 32'hFFFF_FFFF : {24'h0, rx_mem[rx_rptr[FW-1:0]]};
            OFF_STATUS: mmio_rdata = {8'h0, 8'(tx_cnt), 8'(rx_cnt),
                                      4'h0, rx_full, tx_empty, tx_full, ~rx_empty};
            OFF_CYCLE:  mmio_rdata = cycle_cnt;
            default:    mmio_rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_idx] <= di;
        if (tx_push) tx_mem[tx_wptr[FW-1:0]] <= di[7:0];
        if (rx_push) rx_mem[rx_wptr[FW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout      <= 32'h0;
            tx_wptr   <= '0;
            tx_rptr   <= '0;
            rx_wptr   <= '0;
            rx_rptr   <= '0;
            cycle_cnt <= 32'h0;
        end else begin
            if (ram_re) dout <= is_mmio ? mmio_rdata : mem[ram_idx];
            if (tx_push) tx_wptr <= tx_wptr + 1'b1;
            if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
            if (rx_push) rx_wptr <= rx_wptr + 1'b1;
            if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
            cycle_cnt <= cyc_load ? di : cycle_cnt + 32'h1;
        end
    end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed self-checking bench for dmem_mmio_responder: RAM, TX/RX FIFOs, status,
// cycle counter and mid-stream reset.
module tb_dmem_mmio_responder;
    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst, en, we, tx_ready, rx_valid;
    logic [31:0] addr, di;
    logic [7:0]  rx_data;
    logic [31:0] dout;
    logic        stall, tx_valid, rx_ready;
    logic [7:0]  tx_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_mmio_responder dut (
        .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .di(di),
        .dout(dout), .stall(stall), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        en = 1'b1; we = 1'b1; addr = a; di = d;
        step();
        en = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        en = 1'b1; we = 1'b0; addr = a;
        step();
        en = 1'b0;
        d = dout;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        step();
        step();
        total += 4;
        if (dout !== 32'h0)   begin bad++; $display("FAIL reset_dout got=%h exp=0", dout); end
        if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        if (rx_ready !== 1'b0) begin bad++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
        if (stall !== 1'b0)    begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        rst = 1'b0;
        rd(BASE + 32'h8, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL reset_status got=%h exp=00000004", d); end
    endtask

    task automatic test_ram();
        logic [31:0] d;
        wr(32'h40, 32'hDEAD_BEEF);
        rd(32'h40, d);
        total++;
        if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_rd got=%h exp=deadbeef", d); end
        wr(32'h44, 32'h1111_2222);
        total++;
        if (dout !== 32'hDEAD_BEEF) begin bad++; $display("FAIL dout_hold got=%h exp=deadbeef", dout); end
        rd(32'h40 + 32'd4096, d);
        total++;
        if (d !== 32'hDEAD_BEEF) begin bad++; $display("FAIL ram_alias got=%h exp=deadbeef", d); end
        rd(32'h47, d);
        total++;
        if (d !== 32'h1111_2222) begin bad++; $display("FAIL ram_lowbits got=%h exp=11112222", d); end
        rd(BASE + 32'h10, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL mmio_other got=%h exp=0", d); end
        rd(BASE, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL tx_data_rd got=%h exp=0", d); end
    endtask

    task automatic test_tx_backpressure();
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            en = 1'b1; we = 1'b1; addr = BASE; di = i;
            #1;
            total++;
            if (stall !== (i == 16)) begin
                bad++; $display("FAIL tx_stall i=%0d got=%b exp=%b", i, stall, (i == 16));
            end
            if (i < 16) step();
        end
        tx_ready = 1'b1;
        total++;
        if (tx_data !== 8'd0) begin bad++; $display("FAIL tx_head got=%h exp=00", tx_data); end
        step();
        tx_ready = 1'b0;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL tx_stall_drop got=%b exp=0", stall); end
        step();
        en = 1'b0; we = 1'b0;
        tx_ready = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            total++;
            if (tx_valid !== 1'b1 || tx_data !== k[7:0]) begin
                bad++; $display("FAIL tx_drain k=%0d got=%b/%h exp=1/%h", k, tx_valid, tx_data, k[7:0]);
            end
            step();
        end
        tx_ready = 1'b0;
        total++;
        if (tx_valid !== 1'b0) begin bad++; $display("FAIL tx_empty got=%b exp=0", tx_valid); end
    endtask

    task automatic test_rx_path();
        logic [31:0] d;
        rx_valid = 1'b1; rx_data = 8'h41;
        step();
        rx_data = 8'h42;
        step();
        rx_valid = 1'b0;
        rd(BASE + 32'h8, d);
        total++;
        if (d !== 32'h0000_0205) begin bad++; $display("FAIL rx_status2 got=%h exp=00000205", d); end
        rd(BASE + 32'h4, d);
        total++;
        if (d !== 32'h41) begin bad++; $display("FAIL rx_pop0 got=%h exp=00000041", d); end
        rd(BASE + 32'h4, d);
        total++;
        if (d !== 32'h42) begin bad++; $display("FAIL rx_pop1 got=%h exp=00000042", d); end
        rd(BASE + 32'h4, d);
        total++;
        if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rx_empty_rd got=%h exp=ffffffff", d); end
        rd(BASE + 32'h8, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL rx_status0 got=%h exp=00000004", d); end
    endtask

    task automatic test_rx_full();
        logic [31:0] d;
        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'h10 + i[7:0];
            step();
        end
        total++;
        if (rx_ready !== 1'b0) begin bad++; $display("FAIL rx_full_ready got=%b exp=0", rx_ready); end
        rd(BASE + 32'h8, d);
        total++;
        if (d !== 32'h0000_100D) begin bad++; $display("FAIL rx_full_status got=%h exp=0000100d", d); end
        rd(BASE + 32'h4, d);
        total++;
        if (d !== 32'h10) begin bad++; $display("FAIL rx_full_pop got=%h exp=00000010", d); end
        total++;
        if (rx_ready !== 1'b1) begin bad++; $display("FAIL rx_ready_back got=%b exp=1", rx_ready); end
        rx_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            rd(BASE + 32'h4, d);
            total++;
            if (d !== 32'h10 + i) begin bad++; $display("FAIL rx_drain i=%0d got=%h exp=%h", i, d, 32'h10 + i); end
        end
        rd(BASE + 32'h4, d);
        total++;
        if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL rx_drain_end got=%h exp=ffffffff", d); end
    endtask

    task automatic test_cycle();
        wr(BASE + 32'hC, 32'hFFFF_FFFE);
        en = 1'b1; we = 1'b0; addr = BASE + 32'hC;
        step();
        total++;
        if (dout !== 32'hFFFF_FFFE) begin bad++; $display("FAIL cyc0 got=%h exp=fffffffe", dout); end
        step();
        total++;
        if (dout !== 32'hFFFF_FFFF) begin bad++; $display("FAIL cyc1 got=%h exp=ffffffff", dout); end
        step();
        en = 1'b0;
        total++;
        if (dout !== 32'h0) begin bad++; $display("FAIL cyc_wrap got=%h exp=0", dout); end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] d;
        wr(32'h80, 32'h1234_5678);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) wr(BASE, 32'hA0 + i);
        rx_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rx_data = 8'hB0 + i[7:0];
            step();
        end
        rx_valid = 1'b0;
        rd(BASE + 32'h8, d);
        total++;
        if (d !== 32'h0005_0301) begin bad++; $display("FAIL pre_rst_status got=%h exp=00050301", d); end
        rst = 1'b1;
        step();
        total += 2;
        if (dout !== 32'h0)    begin bad++; $display("FAIL mid_rst_dout got=%h exp=0", dout); end
        if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_tx_valid got=%b exp=0", tx_valid); end
        rst = 1'b0;
        rd(BASE + 32'hC, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL post_rst_cycle got=%h exp=0", d); end
        total++;
        if (tx_valid !== 1'b0) begin bad++; $display("FAIL post_rst_tx_valid got=%b exp=0", tx_valid); end
        rd(BASE + 32'h8, d);
        total++;
        if (d !== 32'h4) begin bad++; $display("FAIL post_rst_status got=%h exp=00000004", d); end
        rd(32'h80, d);
        total++;
        if (d !== 32'h1234_5678) begin bad++; $display("FAIL post_rst_ram got=%h exp=12345678", d); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; we = 1'b0; addr = 32'h0; di = 32'h0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h0;
        test_reset();
        test_ram();
        test_tx_backpressure();
        test_rx_path();
        test_rx_full();
        test_cycle();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
